// File: rtl/lap_stopwatch_core.sv
// lap_stopwatch_core: MM:SS:CC BCD stopwatch fed by level buttons, with lap capture.
// Build option LAP_MEMORY_EN: when defined, a LAP_DEPTH-entry lap memory with
// recall (VIEW state) is built. When undefined, lap acts as a single split-freeze
// of the display and lap_count/lap_full stay 0.
module lap_stopwatch_core #(
  parameter int CLK_DIV   = 100000,
  parameter int LAP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        btn_start_stop,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [23:0] disp_bcd,
  output logic        disp_update,
  output logic        running,
  output logic        lap_view,
  output logic [3:0]  lap_count,
  output logic        lap_full
);

  localparam int            PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_VIEW} state_t;

  state_t        state_q, state_d;
  logic [2:0]    sync_ss_q, sync_lap_q, sync_clr_q;
  logic          ev_ss_q, ev_lap_q, ev_clr_q;
  logic          ev_ss, ev_lap, ev_clr;
  logic [PW-1:0] presc_q;
  logic [23:0]   time_q;
  logic          do_clear;
  logic [23:0]   disp_prev_q;

`ifdef LAP_MEMORY_EN
  logic          lap_wr, view_start, view_next;
  logic [3:0]    lap_cnt_q, idx_q;
  logic [23:0]   lap_mem [16];
`else
  logic          frz_toggle, frz_release;
  logic          frz_q;
  logic [23:0]   frz_time_q;
`endif

  // One-centisecond BCD increment with digit-wise carries; 59:59:99 wraps to 0.
  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [3:0] m1, m0, s1, s0, c1, c0;
    {m1, m0, s1, s0, c1, c0} = t;
    if (c0 != 4'd9) c0 = c0 + 4'd1;
    else begin
      c0 = 4'd0;
      if (c1 != 4'd9) c1 = c1 + 4'd1;
      else begin
        c1 = 4'd0;
        if (s0 != 4'd9) s0 = s0 + 4'd1;
        else begin
          s0 = 4'd0;
          if (s1 != 4'd5) s1 = s1 + 4'd1;
          else begin
            s1 = 4'd0;
            if (m0 != 4'd9) m0 = m0 + 4'd1;
            else begin
              m0 = 4'd0;
              if (m1 != 4'd5) m1 = m1 + 4'd1;
              else m1 = 4'd0;
            end
          end
        end
      end
    end
    return {m1, m0, s1, s0, c1, c0};
  endfunction

  // Button conditioning: two sync flops, a delay flop, and a registered rise event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ss_q  <= '0;
      sync_lap_q <= '0;
      sync_clr_q <= '0;
      ev_ss_q    <= 1'b0;
      ev_lap_q   <= 1'b0;
      ev_clr_q   <= 1'b0;
    end else if (ena) begin
      // NOTE: non-blocking so each stage samples its pre-edge value; blocking
      // assignments here would collapse the synchroniser chain into one flop.
      sync_ss_q  <= {sync_ss_q[1:0],  btn_start_stop};
      sync_lap_q <= {sync_lap_q[1:0], btn_lap};
      sync_clr_q <= {sync_clr_q[1:0], btn_clear};
      ev_ss_q    <= sync_ss_q[1]  & ~sync_ss_q[2];
      ev_lap_q   <= sync_lap_q[1] & ~sync_lap_q[2];
      ev_clr_q   <= sync_clr_q[1] & ~sync_clr_q[2];
    end
  end

  // Only the highest-priority coincident event survives: clear > start_stop > lap.
  assign ev_clr = ev_clr_q;
  assign ev_ss  = ev_ss_q & ~ev_clr_q;
  assign ev_lap = ev_lap_q & ~ev_ss_q & ~ev_clr_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state_q <= S_IDLE;
    else if (ena) state_q <= state_d;
  end

  // FSM next-state and control strobes.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    do_clear = 1'b0;
`ifdef LAP_MEMORY_EN
    lap_wr     = 1'b0;
    view_start = 1'b0;
    view_next  = 1'b0;
`else
    frz_toggle  = 1'b0;
    frz_release = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (ev_ss) state_d = S_RUN;
      S_RUN: begin
        if (ev_ss) begin
          state_d = S_STOP;
`ifndef LAP_MEMORY_EN
          frz_release = 1'b1;
`endif
        end else if (ev_lap) begin
`ifdef LAP_MEMORY_EN
          lap_wr = ~lap_full;
`else
          frz_toggle = 1'b1;
`endif
        end
      end
      S_STOP: begin
        if (ev_clr) begin
          state_d  = S_IDLE;
          do_clear = 1'b1;
        end else if (ev_ss) begin
          state_d = S_RUN;
        end
`ifdef LAP_MEMORY_EN
        else if (ev_lap && lap_cnt_q != 4'd0) begin
          state_d    = S_VIEW;
          view_start = 1'b1;
        end
`endif
      end
      S_VIEW: begin
`ifdef LAP_MEMORY_EN
        if (ev_clr) begin
          state_d  = S_IDLE;
          do_clear = 1'b1;
        end else if (ev_ss) begin
          state_d = S_RUN;
        end else if (ev_lap) begin
          if (idx_q == lap_cnt_q - 4'd1) state_d = S_STOP;
          else                           view_next = 1'b1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prescaler and BCD time: one centisecond per CLK_DIV enabled cycles in RUN.
  // Outside RUN the prescaler holds, preserving the fractional tick across STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      time_q  <= '0;
    end else if (ena) begin
      if (do_clear) begin
        presc_q <= '0;
        time_q  <= '0;
      end else if (state_q == S_RUN) begin
        if (presc_q == PRESC_MAX) begin
          presc_q <= '0;
          time_q  <= bcd_inc(time_q);
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
    end
  end

`ifdef LAP_MEMORY_EN
  // Lap storage: an accepted lap stores the time registered in that cycle (pre-tick).
  // NOTE: the lap memory has no reset; entries at or above lap_count are never read.
  always_ff @(posedge clk) begin
    if (ena && lap_wr) lap_mem[lap_cnt_q] <= time_q;
  end

  // Lap count and recall index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_cnt_q <= '0;
      idx_q     <= '0;
    end else if (ena) begin
      if (do_clear) begin
        lap_cnt_q <= '0;
        idx_q     <= '0;
      end else begin
        if (lap_wr) lap_cnt_q <= lap_cnt_q + 4'd1;
        if (view_start)     idx_q <= '0;
        else if (view_next) idx_q <= idx_q + 4'd1;
      end
    end
  end

  assign lap_count = lap_cnt_q;
  assign lap_full  = (lap_cnt_q == 4'(LAP_DEPTH));
  assign lap_view  = (state_q == S_VIEW);
  assign disp_bcd  = lap_view ? lap_mem[idx_q] : time_q;
`else
  // Split freeze: first lap in RUN latches the display, the next one releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frz_q      <= 1'b0;
      frz_time_q <= '0;
    end else if (ena) begin
      if (do_clear || frz_release) begin
        frz_q <= 1'b0;
      end else if (frz_toggle) begin
        frz_q <= ~frz_q;
        if (!frz_q) frz_time_q <= time_q;
      end
    end
  end

  assign lap_count = 4'd0;
  // lap_count is 0 in this build, so this is 0 for every legal LAP_DEPTH (>= 1).
  assign lap_full  = (lap_count == 4'(LAP_DEPTH));
  assign lap_view  = frz_q;
  assign disp_bcd  = frz_q ? frz_time_q : time_q;
`endif

  assign running = (state_q == S_RUN);

  // Display-change strobe. Deliberately not gated by ena, so it always falls
  // back to 0 once disp_bcd stops changing (disp_bcd itself is frozen by ena).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_prev_q <= '0;
      disp_update <= 1'b0;
    end else begin
      disp_prev_q <= disp_bcd;
      disp_update <= (disp_bcd != disp_prev_q);
    end
  end

endmodule

// File: doc/lap_stopwatch_core.md
# lap_stopwatch_core

Parametrised stopwatch core with a multi-entry lap memory and recall mode, counting MM:SS:CC in BCD from a prescaled system clock. It sits between the board button inputs and the serial 7-segment display driver. It takes raw synchronous-level buttons and presents six BCD digits plus a one-cycle update strobe that the driver uses to start a new display frame. It generalises the single-run stopwatch with a configurable tick rate, lap depth and lap recall.

## Interface
- `CLK_DIV`, default 100000: clk cycles per centisecond tick; legal range ≥ 2.
- `LAP_DEPTH`, default 4: number of lap entries stored; legal range 1–15.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  global enable; when low, every register holds its value.
- `btn_start_stop`  in  1  start/stop button, active-high level.
- `btn_lap`  in  1  lap button, active-high level.
- `btn_clear`  in  1  clear button, active-high level.
- `disp_bcd`  out  24  displayed time as {m1, m0, s1, s0, c1, c0}, 4 bits per digit.
- `disp_update`  out  1  one-cycle pulse in the cycle after `disp_bcd` changes.
- `running`  out  1  high in RUN.
- `lap_view`  out  1  high in VIEW.
- `lap_count`  out  4  number of stored laps, 0..LAP_DEPTH.
- `lap_full`  out  1  high when `lap_count == LAP_DEPTH`.

## Operation
- **Button conditioning:** each button passes through a 2-flop synchroniser and then a rising-edge detector, giving one event per press. Debouncing is done upstream.
- **Event priority:** when events coincide, clear > start_stop > lap. Only the highest-priority event acts; the others are dropped.
- **IDLE:** time is 00:00:00.
  - start_stop → RUN.
  - lap and clear are ignored.
- **RUN:** the prescaler counts 0..CLK_DIV-1; its wrap increments the time by one centisecond.
  - start_stop → STOP.
  - lap → the current time is written to `lap_mem[lap_count]` and `lap_count` increments. When `lap_full` is set, the lap is dropped and the count is unchanged.
  - clear is ignored.
- **STOP:** time and prescaler hold. The prescaler is not reset, so the fractional tick is preserved.
  - start_stop → RUN.
  - lap with `lap_count > 0` → VIEW with index 0.
  - lap with `lap_count == 0` is ignored.
  - clear → IDLE.
- **VIEW:** `disp_bcd` shows `lap_mem[idx]`.
  - lap → idx+1; when idx is the last stored entry, → STOP, showing live time.
  - start_stop → RUN, with live time shown.
  - clear → IDLE.
- **Clear:** sets time, prescaler, `lap_count` and idx to 0. Lap memory contents need not be zeroed and are never shown.
- **BCD arithmetic:**
  - c0 9→0 carries into c1.
  - c1 9→0 carries into s0.
  - s0 9→0 carries into s1.
  - s1 5→0 carries into m0.
  - m0 9→0 carries into m1.
  - m1 5→0 wraps 59:59:99 → 00:00:00 with no flag.
- **Display source:** `disp_bcd` is live time in IDLE, RUN and STOP, and the lap entry in VIEW.

## Timing
- **Reset:** all outputs are 0 and the state is IDLE. Reset mid-run discards all time and laps immediately, asynchronously.
- **Event latency:** a button high at clock edge k produces the state and output change at edge k+3. This is 2 synchroniser cycles plus 1 edge/FSM cycle.
- **Tick latency:** in RUN, time increments exactly once per CLK_DIV enabled cycles. The first increment after entering RUN from IDLE occurs CLK_DIV cycles after the RUN edge.
- **Lap capture:** a lap event stores the time value registered in that same cycle. If a tick coincides with the lap event, the stored value is the pre-increment time.
- **disp_update:** registered, asserted for exactly one cycle following any cycle where `disp_bcd` changed. It is never asserted while `disp_bcd` is constant.
- **ena low:** synchronisers, prescaler, counters and FSM all freeze. No events are lost while `ena` is high.

## Configuration
- `LAP_MEMORY_EN` defined: behaviour as above.
- `LAP_MEMORY_EN` undefined: no lap memory is built and `LAP_DEPTH` is ignored.
  - `lap_count` and `lap_full` are tied to 0, and VIEW is unreachable.
  - Lap in RUN toggles a split freeze: `disp_bcd` holds the time captured at the lap edge while counting continues, and `lap_view` is high during the freeze. The next lap, or start_stop, releases the freeze.
  - Lap in STOP is ignored.
  - Clear also releases the freeze.

## Test plan
- **Basic run:** CLK_DIV=4; reset, start_stop pulse, run 400 cycles → `disp_bcd` = 00:00:99 or 00:01:00 per exact edge alignment. Check one increment every 4 cycles and one `disp_update` per increment.
- **Wrap-around:** preload by running to 59:59:99, apply 1 more tick → 00:00:00 with `running` still 1.
- **Lap memory:** LAP_DEPTH=2; in RUN press lap 3 times at distinct times → `lap_count`=2, `lap_full`=1, third lap dropped. Then stop and lap ×3 → shows lap0, lap1, then live time, with `lap_view` 1,1,0.
- **Simultaneous events:** in STOP with laps stored, assert clear and lap in the same cycle → IDLE, 00:00:00, `lap_count`=0. Assert start_stop and lap in the same cycle in RUN → STOP and no lap stored.
- **Reset and ena:** assert `rst_n`=0 mid-RUN → all outputs 0 asynchronously. With `ena`=0 for 50 cycles in RUN → time unchanged.
- **Split mode:** with `LAP_MEMORY_EN` undefined, lap in RUN → display frozen while internal time advances. Second lap → live time shown, `lap_view`=0.
